// File: rtl/btn_debounce_rpt.sv
// rtl/btn_debounce_rpt.sv - per-button 2-FF sync, ce-tick debounce, press strobe with optional auto-repeat
// Auto-repeat is built only when BTN_AUTOREPEAT_EN is defined; otherwise a single strobe per press.
module btn_debounce_rpt #(
  parameter int N_BTN         = 4,
  parameter int DEB_MS        = 10,
  parameter int RPT_DELAY_MS  = 500,
  parameter int RPT_PERIOD_MS = 100,
  parameter int CNT_W         = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] btn_lvl,
  output logic [N_BTN-1:0] btn_pulse
);

  localparam logic [CNT_W-1:0] DEB_TERM = CNT_W'(DEB_MS - 1);

  logic [N_BTN-1:0] sync_a;
  logic [N_BTN-1:0] sync_b;
  logic [N_BTN-1:0] rise;
  logic [N_BTN-1:0] fall;
  logic [CNT_W-1:0] dcnt [N_BTN];
  logic [1:0]       state [N_BTN];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= btn_in;
      sync_b <= sync_a;
    end
  end

  // rise/fall mark the exact edge on which btn_lvl is about to change
  always_comb begin
    rise = '0;
    fall = '0;
    for (int i = 0; i < N_BTN; i++) begin
      if (ce && (sync_b[i] != btn_lvl[i]) && (dcnt[i] == DEB_TERM)) begin
        rise[i] = sync_b[i];
        fall[i] = ~sync_b[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      btn_lvl <= '0;
      for (int i = 0; i < N_BTN; i++) dcnt[i] <= '0;
    end else if (ce) begin
      for (int i = 0; i < N_BTN; i++) begin
        if (sync_b[i] == btn_lvl[i]) begin
          dcnt[i] <= '0;
        end else if (dcnt[i] == DEB_TERM) begin
          btn_lvl[i] <= sync_b[i];
          dcnt[i]    <= '0;
        end else begin
          dcnt[i] <= dcnt[i] + 1'b1;
        end
      end
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DELAY  = 2'd1;
  localparam logic [1:0] ST_REPEAT = 2'd2;
  localparam logic [CNT_W-1:0] DLY_TERM = CNT_W'(RPT_DELAY_MS - 1);
  localparam logic [CNT_W-1:0] PER_TERM = CNT_W'(RPT_PERIOD_MS - 1);

  logic [CNT_W-1:0] rcnt [N_BTN];

  // A due repeat waits one clk if the previous clk already strobed, so strobes never abut
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      btn_pulse <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        state[i] <= ST_IDLE;
        rcnt[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        btn_pulse[i] <= 1'b0;
        case (state[i])
          ST_IDLE: begin
            if (rise[i]) begin
              btn_pulse[i] <= 1'b1;
              rcnt[i]      <= '0;
              state[i]     <= ST_DELAY;
            end
          end
          ST_DELAY: begin
            if (fall[i]) begin
              state[i] <= ST_IDLE;
              rcnt[i]  <= '0;
            end else if (ce) begin
              if (rcnt[i] == DLY_TERM) begin
                if (!btn_pulse[i]) begin
                  btn_pulse[i] <= 1'b1;
                  rcnt[i]      <= '0;
                  state[i]     <= ST_REPEAT;
                end
              end else begin
                rcnt[i] <= rcnt[i] + 1'b1;
              end
            end
          end
          ST_REPEAT: begin
            if (fall[i]) begin
              state[i] <= ST_IDLE;
              rcnt[i]  <= '0;
            end else if (ce) begin
              if (rcnt[i] == PER_TERM) begin
                if (!btn_pulse[i]) begin
                  btn_pulse[i] <= 1'b1;
                  rcnt[i]      <= '0;
                end
              end else begin
                rcnt[i] <= rcnt[i] + 1'b1;
              end
            end
          end
          default: begin
            state[i] <= ST_IDLE;
            rcnt[i]  <= '0;
          end
        endcase
      end
    end
  end
`else
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HELD = 2'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      btn_pulse <= '0;
      for (int i = 0; i < N_BTN; i++) state[i] <= ST_IDLE;
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        btn_pulse[i] <= 1'b0;
        case (state[i])
          ST_IDLE: begin
            if (rise[i]) begin
              btn_pulse[i] <= 1'b1;
              state[i]     <= ST_HELD;
            end
          end
          ST_HELD: begin
            if (fall[i]) state[i] <= ST_IDLE;
          end
          default: state[i] <= ST_IDLE;
        endcase
      end
    end
  end
`endif

endmodule

// File: tb/tb_btn_debounce_rpt.sv
// tb/tb_btn_debounce_rpt.sv - scoreboard bench for btn_debounce_rpt
// Repeat-strobe expectations follow BTN_AUTOREPEAT_EN.
module tb_btn_debounce_rpt;

  typedef struct {
    int         cyc;
    logic [3:0] lvl;
    logic [3:0] pulse;
  } evt_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ce = 1'b1;
  logic       ce_div;
  logic [3:0] btn_in;
  logic [3:0] btn_lvl;
  logic [3:0] btn_pulse;

  int         cyc = 0;
  logic       rst_q = 1'b0;
  logic       done;
  logic [3:0] prev_lvl;
  int         checks = 0;
  int         errors = 0;
  evt_t       q[$];
  evt_t       mon_e;

  btn_debounce_rpt #(
    .N_BTN(4), .DEB_MS(4), .RPT_DELAY_MS(8), .RPT_PERIOD_MS(3), .CNT_W(10)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .btn_in(btn_in),
    .btn_lvl(btn_lvl), .btn_pulse(btn_pulse)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst_n;
  end

  // ce ticks land on posedges whose index is a multiple of 4 when divided
  always @(negedge clk) ce = ce_div ? (((cyc + 1) % 4) == 0) : 1'b1;

  function automatic void push(input int c, input logic [3:0] l, input logic [3:0] p);
    evt_t e;
    e.cyc = c;
    e.lvl = l;
    e.pulse = p;
    q.push_back(e);
  endfunction

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic press_release(input logic [3:0] m);
    int c;
    c = cyc;
    btn_in = m;
    push(c + 6, m, m);
    wait_until(c + 6);
    btn_in = 4'h0;
    push(c + 12, 4'h0, 4'h0);
    wait_until(c + 14);
  endtask

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc < cyc) begin
      checks++;
      errors++;
      $display("FAIL missing_event due_cyc=%0d exp_lvl=%b exp_pulse=%b", q[0].cyc, q[0].lvl, q[0].pulse);
      void'(q.pop_front());
    end
    if (!rst_q) begin
      checks++;
      if (btn_lvl !== 4'h0 || btn_pulse !== 4'h0) begin
        errors++;
        $display("FAIL reset_outputs cyc=%0d lvl=%b pulse=%b required 0000/0000", cyc, btn_lvl, btn_pulse);
      end
    end else if (btn_pulse !== 4'h0 || btn_lvl !== prev_lvl) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event cyc=%0d lvl=%b pulse=%b", cyc, btn_lvl, btn_pulse);
      end else begin
        mon_e = q.pop_front();
        if (mon_e.cyc != cyc || mon_e.lvl !== btn_lvl || mon_e.pulse !== btn_pulse) begin
          errors++;
          $display("FAIL event cyc=%0d lvl=%b pulse=%b required cyc=%0d lvl=%b pulse=%b",
                   cyc, btn_lvl, btn_pulse, mon_e.cyc, mon_e.lvl, mon_e.pulse);
        end
      end
    end
    prev_lvl = btn_lvl;
    if (done) begin
      checks++;
      if (q.size() != 0) begin
        errors++;
        $display("FAIL leftover_events count=%0d required 0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  end

  initial begin
    int c;
    int p;
    rst_n  = 1'b0;
    btn_in = 4'hF;
    ce_div = 1'b0;
    done   = 1'b0;

    // reset with all buttons held, then fresh debounce of all four
    wait_until(3);
    rst_n = 1'b1;
    push(9, 4'hF, 4'hF);
    wait_until(9);
    btn_in = 4'h0;
    push(15, 4'h0, 4'h0);
    wait_until(18);

    press_release(4'b0001);
    press_release(4'b1001);

    // bounce on btn1: high 3, low 1, high 7
    c = cyc;
    btn_in = 4'b0010;
    wait_until(c + 3);
    btn_in = 4'b0000;
    wait_until(c + 4);
    btn_in = 4'b0010;
    push(c + 10, 4'b0010, 4'b0010);
    wait_until(c + 11);
    btn_in = 4'b0000;
    push(c + 17, 4'b0000, 4'b0000);
    wait_until(c + 20);

    // held 30 clks on btn2
    c = cyc;
    p = c + 6;
    btn_in = 4'b0100;
    push(p, 4'b0100, 4'b0100);
`ifdef BTN_AUTOREPEAT_EN
    for (int j = 8; j < 30; j += 3) push(p + j, 4'b0100, 4'b0100);
`endif
    wait_until(c + 30);
    btn_in = 4'b0000;
    push(p + 30, 4'b0000, 4'b0000);
    wait_until(p + 33);

    // release lands on the same edge as the first repeat: release wins
    c = cyc;
    p = c + 6;
    btn_in = 4'b1000;
    push(p, 4'b1000, 4'b1000);
    wait_until(c + 8);
    btn_in = 4'b0000;
    push(p + 8, 4'b0000, 4'b0000);
    wait_until(p + 12);

    // ce every 4th clk
    ce_div = 1'b1;
    wait_until(cyc + 3);
    while ((cyc % 4) != 0) @(negedge clk);
    c = cyc;
    btn_in = 4'b0001;
    push(c + 16, 4'b0001, 4'b0001);
    wait_until(c + 16);
    btn_in = 4'b0000;
    push(c + 32, 4'b0000, 4'b0000);
    wait_until(c + 34);
    ce_div = 1'b0;
    wait_until(cyc + 4);

    // reset mid-hold, button still held afterwards
    c = cyc;
    btn_in = 4'b0001;
    push(c + 6, 4'b0001, 4'b0001);
    wait_until(c + 8);
    rst_n = 1'b0;
    wait_until(c + 10);
    rst_n = 1'b1;
    push(c + 16, 4'b0001, 4'b0001);
    wait_until(c + 16);
    btn_in = 4'b0000;
    push(c + 22, 4'b0000, 4'b0000);
    wait_until(c + 26);

    done = 1'b1;
  end

endmodule
